// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus microcontroller control path:
// word width, IR field positions, sub-op codes, sequencer states and the
// control word that the sequencer drives onto the datapath.
package cpu_pkg;

    localparam int WORD_W    = 16;
    localparam int CLASS_BIT = 15;   // 1 = ALU op, 0 = sub-op class
    localparam int OP_HI     = 14;
    localparam int OP_LO     = 12;
    localparam int RD_HI     = 11;
    localparam int RD_LO     = 10;
    localparam int RA_HI     = 9;
    localparam int RA_LO     = 8;
    localparam int RB_HI     = 7;
    localparam int RB_LO     = 6;

    typedef enum logic [2:0] {
        SUB_NOP   = 3'b000,
        SUB_LOAD  = 3'b001,
        SUB_STORE = 3'b010,
        SUB_MOV   = 3'b011,
        SUB_IN    = 3'b100,
        SUB_OUT   = 3'b101,
        SUB_HALT  = 3'b110,
        SUB_RSVD  = 3'b111
    } subop_t;

    typedef enum logic [4:0] {
        S_F0, S_FW, S_FL, S_FI, S_DEC,
        S_A1, S_A2, S_A3, S_A4,
        S_MA, S_RW, S_RL, S_RB,
        S_SD, S_WW,
        S_MV, S_IN, S_OU, S_NP,
        S_HT, S_ER
    } state_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_inc;
        logic       mar_en;
        logic       mdr_en_write;
        logic       mdr_en_read;
        logic       mdr_out;
        logic       ir_en;
        logic       mem_en;
        logic       mem_rw;
        logic       alu_in1;
        logic       alu_in2;
        logic       alu_outlach;
        logic       alu_out_en;
        logic [3:0] g_in;
        logic [3:0] g_out;
        logic       p0_in;
        logic       p1_out;
        logic       halted;
        logic       err;
        logic       instr_done;
    } ctrl_t;

    function automatic logic [3:0] onehot4(logic [1:0] r);
        return 4'b0001 << r;
    endfunction

    function automatic logic is_wait(state_t s);
        return (s == S_FW) || (s == S_RW) || (s == S_WW);
    endfunction

    // Moore control word for a state; the WW completion pulse depends on MFC
    // and is added by the sequencer itself.
    function automatic ctrl_t decode(state_t s, logic [1:0] rd_f,
                                     logic [1:0] ra_f, logic [1:0] rb_f);
        ctrl_t c;
        c = '0;
        case (s)
            S_F0:       begin c.pc_out = 1'b1; c.mar_en = 1'b1; end
            S_FW, S_RW: begin c.mem_en = 1'b1; c.mem_rw = 1'b1; end
            S_FL, S_RL: begin c.mem_en = 1'b1; c.mem_rw = 1'b1; c.mdr_en_read = 1'b1; end
            S_FI:       begin c.mdr_out = 1'b1; c.ir_en = 1'b1; c.pc_inc = 1'b1; end
            S_A1:       begin c.g_out = onehot4(ra_f); c.alu_in1 = 1'b1; end
            S_A2:       begin c.g_out = onehot4(rb_f); c.alu_in2 = 1'b1; end
            S_A3:       c.alu_outlach = 1'b1;
            S_A4:       begin c.alu_out_en = 1'b1; c.g_in = onehot4(rd_f); c.instr_done = 1'b1; end
            S_MA:       begin c.g_out = onehot4(ra_f); c.mar_en = 1'b1; end
            S_RB:       begin c.mdr_out = 1'b1; c.g_in = onehot4(rd_f); c.instr_done = 1'b1; end
            S_SD:       begin c.g_out = onehot4(rd_f); c.mdr_en_write = 1'b1; end
            S_WW:       c.mem_en = 1'b1;
            S_MV:       begin c.g_out = onehot4(ra_f); c.g_in = onehot4(rd_f); c.instr_done = 1'b1; end
            S_IN:       begin c.p1_out = 1'b1; c.g_in = onehot4(rd_f); c.instr_done = 1'b1; end
            S_OU:       begin c.g_out = onehot4(ra_f); c.p0_in = 1'b1; c.instr_done = 1'b1; end
            S_NP:       c.instr_done = 1'b1;
            S_HT:       c.halted = 1'b1;
            S_ER:       begin c.halted = 1'b1; c.err = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait-cycle counter. Cleared while outside a wait state so every
// wait starts from zero; expired flags the last acceptable wait cycle.
module wait_timer #(
    parameter int MAX = 15,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    // count wait cycles, holding once the last one is reached
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == W'(MAX - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 16-bit single-bus
// datapath. Control outputs are registered from the next state; rst forces
// the fetch-start word immediately so nothing partial reaches the datapath.
import cpu_pkg::*;

module control_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        MFC,
    output logic        PC_Out,
    output logic        PC_inc,
    output logic        MAR_EN,
    output logic        MDR_EN_write,
    output logic        MDR_EN_read,
    output logic        MDR_out,
    output logic        IR_EN,
    output logic        mem_EN,
    output logic        mem_RW,
    output logic        ALUin1,
    output logic        ALUin2,
    output logic        ALU_outlach,
    output logic        ALU_outEN,
    output logic [3:0]  G_in,
    output logic [3:0]  G_out,
    output logic        P0_in,
    output logic        P1_out,
    output logic        halted,
    output logic        err,
    output logic        instr_done
);

    state_t     state, state_nx;
    ctrl_t      ctrl_q, ctrl;
    subop_t     sub;
    logic       in_wait, expired;
    logic [1:0] rd_f, ra_f, rb_f;
    logic       unused_ir;

    assign sub       = subop_t'(ir[OP_HI:OP_LO]);
    assign rd_f      = ir[RD_HI:RD_LO];
    assign ra_f      = ir[RA_HI:RA_LO];
    assign rb_f      = ir[RB_HI:RB_LO];
    assign unused_ir = ^ir[RB_LO-1:0];
    assign in_wait   = is_wait(state);

    wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (expired)
    );

    // next-state: fetch, decode on the IR, execute paths, terminal halts
    always_comb begin
        state_nx = state;
        case (state)
            S_F0:  state_nx = S_FW;
            S_FW:  if (MFC) state_nx = S_FL; else if (expired) state_nx = S_ER;
            S_FL:  state_nx = S_FI;
            S_FI:  state_nx = S_DEC;
            S_DEC: begin
                if (ir[CLASS_BIT]) state_nx = S_A1;
                else begin
                    case (sub)
                        SUB_LOAD, SUB_STORE: state_nx = S_MA;
                        SUB_MOV:             state_nx = S_MV;
                        SUB_IN:              state_nx = S_IN;
                        SUB_OUT:             state_nx = S_OU;
                        SUB_HALT:            state_nx = S_HT;
                        default:             state_nx = S_NP;
                    endcase
                end
            end
            S_A1:  state_nx = S_A2;
            S_A2:  state_nx = S_A3;
            S_A3:  state_nx = S_A4;
            S_MA:  state_nx = (sub == SUB_LOAD) ? S_RW : S_SD;
            S_RW:  if (MFC) state_nx = S_RL; else if (expired) state_nx = S_ER;
            S_RL:  state_nx = S_RB;
            S_SD:  state_nx = S_WW;
            S_WW:  if (MFC) state_nx = S_F0; else if (expired) state_nx = S_ER;
            S_A4, S_RB, S_MV, S_IN, S_OU, S_NP: state_nx = S_F0;
            S_HT:  state_nx = S_HT;
            S_ER:  state_nx = S_ER;
            default: state_nx = S_F0;
        endcase
    end

    // state register with the control word registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_F0;
            ctrl_q <= decode(S_F0, rd_f, ra_f, rb_f);
        end else begin
            state  <= state_nx;
            ctrl_q <= decode(state_nx, rd_f, ra_f, rb_f);
        end
    end

    // rst overrides to the fetch-start word; a store completes on its MFC cycle
    always_comb begin
        if (rst)
            ctrl = decode(S_F0, rd_f, ra_f, rb_f);
        else begin
            ctrl = ctrl_q;
            if (state == S_WW && MFC) ctrl.instr_done = 1'b1;
        end
    end

    assign PC_Out       = ctrl.pc_out;
    assign PC_inc       = ctrl.pc_inc;
    assign MAR_EN       = ctrl.mar_en;
    assign MDR_EN_write = ctrl.mdr_en_write;
    assign MDR_EN_read  = ctrl.mdr_en_read;
    assign MDR_out      = ctrl.mdr_out;
    assign IR_EN        = ctrl.ir_en;
    assign mem_EN       = ctrl.mem_en;
    assign mem_RW       = ctrl.mem_rw;
    assign ALUin1       = ctrl.alu_in1;
    assign ALUin2       = ctrl.alu_in2;
    assign ALU_outlach  = ctrl.alu_outlach;
    assign ALU_outEN    = ctrl.alu_out_en;
    assign G_in         = ctrl.g_in;
    assign G_out        = ctrl.g_out;
    assign P0_in        = ctrl.p0_in;
    assign P1_out       = ctrl.p1_out;
    assign halted       = ctrl.halted;
    assign err          = ctrl.err;
    assign instr_done   = ctrl.instr_done;

endmodule
